// File: rtl/lr_pkg.sv
// Shared definitions for the logistic/linear-regression SGD engine.
//
// Purpose: holds the FSM state encoding, the default fixed-point format
// and the saturation limits used by lr_sgd_engine and fx_mul.
// Ports: none (package).
package lr_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_FRAC_W = 8;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_REQ,
    LOAD_CAP,
    FETCH_REQ,
    FETCH_CAP,
    PREDICT,
    UPDATE,
    WRITEBACK,
    DONE
  } lr_state_e;

  // Largest and smallest values representable in a signed word of width w.
  function automatic longint sat_hi(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_lo(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/lr_sgd_engine_if.sv
// Row-memory bus between the SGD engine and its data/weight memory.
//
// Purpose: groups the row-memory signals of lr_sgd_engine.
// Signals:
//   mem_addr  - row address (engine -> memory)
//   mem_rd    - read strobe, data returned on mem_rdata in the next cycle
//   mem_rdata - row read data (memory -> engine)
//   mem_wr    - write strobe
//   mem_wdata - packed weight row to write
// Modports: master (engine side), slave (memory side).
interface lr_sgd_engine_if #(
  parameter int ADDR_W = 4,
  parameter int ROW_W  = 112
);

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [ROW_W-1:0]  mem_rdata;
  logic              mem_wr;
  logic [ROW_W-1:0]  mem_wdata;

  modport master (
    output mem_addr,
    output mem_rd,
    output mem_wr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    input  mem_wr,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/fx_mul.sv
// Signed saturating fixed-point multiplier.
//
// Purpose: p = sat((a * b) >>> FRAC_W) to DATA_W bits, using the full
// double-width product so no precision is lost before the shift.
// Ports:
//   a, b - signed DATA_W-bit operands
//   p    - signed DATA_W-bit saturated product
module fx_mul
  import lr_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] p
);

  localparam int PW = 2 * DATA_W;
  localparam logic signed [PW-1:0] P_MAX = PW'(sat_hi(DATA_W));
  localparam logic signed [PW-1:0] P_MIN = PW'(sat_lo(DATA_W));

  logic signed [PW-1:0] full;
  logic signed [PW-1:0] scaled;

  assign full   = PW'(a) * PW'(b);
  assign scaled = full >>> FRAC_W;

  // Clamp the rescaled product back into the word range instead of wrapping.
  always_comb begin
    if (scaled > P_MAX) begin
      p = P_MAX[DATA_W-1:0];
    end else if (scaled < P_MIN) begin
      p = P_MIN[DATA_W-1:0];
    end else begin
      p = scaled[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/lr_sgd_engine.sv
// Stochastic-gradient-descent training engine for linear regression.
//
// Purpose: loads the weight row (row 0), then for each epoch streams data
// rows 1..num_dps, predicts y_cap = sat(w0 + sum(xi*wi)), forms the scaled
// error c = (y - y_cap) >>> LR_SHIFT and updates every weight, finally
// writing the weight row back to row 0.
// Ports:
//   CLK, RST_N    - clock (rising edge) and async active-low reset
//   start         - begin a run (only looked at in IDLE)
//   num_dps       - data points per epoch, latched at start
//   total_epochs  - epochs to run, latched at start
//   mem           - row-memory bus (master side)
//   busy          - high whenever not IDLE
//   done          - one-cycle pulse at the end of a run
//   epoch         - completed epochs of the current/last run
module lr_sgd_engine
  import lr_pkg::*;
#(
  parameter int NUM_FEATURES = 6,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int FRAC_W       = DEF_FRAC_W,
  parameter int ADDR_W       = 4,
  parameter int LR_SHIFT     = 7
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                start,
  input  logic [ADDR_W-1:0]   num_dps,
  input  logic [7:0]          total_epochs,
  lr_sgd_engine_if.master     mem,
  output logic                busy,
  output logic                done,
  output logic [7:0]          epoch
);

  localparam int ROW_W = DATA_W * (NUM_FEATURES + 1);
  localparam int ACC_W = DATA_W + 6;
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_hi(DATA_W));
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_lo(DATA_W));

  lr_state_e state_q, state_d;

  logic [ADDR_W-1:0] k_q, k_d;
  logic [7:0]        epoch_q, epoch_d;
  logic [ADDR_W-1:0] nd_q;
  logic [7:0]        te_q;
  logic [ADDR_W-1:0] addr_q;

  logic signed [DATA_W-1:0] w_q [0:NUM_FEATURES];
  logic signed [DATA_W-1:0] x_q [1:NUM_FEATURES];
  logic signed [DATA_W-1:0] y_q;
  logic signed [DATA_W-1:0] c_q;

  logic signed [DATA_W-1:0] mul_b [1:NUM_FEATURES];
  logic signed [DATA_W-1:0] prod  [1:NUM_FEATURES];
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] y_cap;
  logic signed [DATA_W-1:0] err;
  logic signed [DATA_W-1:0] c_d;

  function automatic logic signed [DATA_W-1:0] sat_acc(input logic signed [ACC_W-1:0] v);
    if (v > ACC_MAX) begin
      return ACC_MAX[DATA_W-1:0];
    end else if (v < ACC_MIN) begin
      return ACC_MIN[DATA_W-1:0];
    end else begin
      return v[DATA_W-1:0];
    end
  endfunction

  // The multipliers are shared between the two arithmetic phases: in
  // PREDICT they form xi*wi, in UPDATE they form xi*c.
  for (genvar i = 1; i <= NUM_FEATURES; i++) begin : g_mul
    assign mul_b[i] = (state_q == PREDICT) ? w_q[i] : c_q;
    fx_mul #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
    ) u_fx_mul (
      .a (x_q[i]),
      .b (mul_b[i]),
      .p (prod[i])
    );
  end

  // Prediction and error: the dot product is summed wide and saturated once;
  // the error is saturated before the arithmetic shift so it floors.
  always_comb begin
    acc = ACC_W'(w_q[0]);
    for (int i = 1; i <= NUM_FEATURES; i++) begin
      acc = acc + ACC_W'(prod[i]);
    end
    y_cap = sat_acc(acc);
    err   = sat_acc(ACC_W'(y_q) - ACC_W'(y_cap));
    c_d   = err >>> LR_SHIFT;
  end

  // State, row index and epoch counter registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      k_q     <= '0;
      epoch_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      epoch_q <= epoch_d;
    end
  end

  // Next-state logic plus the strobes, which are pure decodes of the state
  // so that an asynchronous reset drops them without waiting for a clock.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    epoch_d    = epoch_q;
    mem.mem_rd = 1'b0;
    mem.mem_wr = 1'b0;
    busy       = (state_q != IDLE);
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_REQ;
          k_d     = '0;
          epoch_d = '0;
        end
      end
      LOAD_REQ: begin
        mem.mem_rd = 1'b1;
        state_d    = LOAD_CAP;
      end
      LOAD_CAP: begin
        if ((nd_q == '0) || (te_q == '0)) begin
          state_d = WRITEBACK;
        end else begin
          state_d = FETCH_REQ;
          k_d     = ADDR_W'(1);
        end
      end
      FETCH_REQ: begin
        mem.mem_rd = 1'b1;
        state_d    = FETCH_CAP;
      end
      FETCH_CAP: state_d = PREDICT;
      PREDICT:   state_d = UPDATE;
      UPDATE: begin
        if (k_q < nd_q) begin
          k_d     = k_q + 1'b1;
          state_d = FETCH_REQ;
        end else begin
          k_d     = ADDR_W'(1);
          epoch_d = epoch_q + 8'd1;
          state_d = (epoch_d == te_q) ? WRITEBACK : FETCH_REQ;
        end
      end
      WRITEBACK: begin
        mem.mem_wr = 1'b1;
        state_d    = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The row address is registered and only changes when entering a state
  // that uses it, so it holds its last value everywhere else.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_q <= '0;
    end else if ((state_d == LOAD_REQ) || (state_d == WRITEBACK)) begin
      addr_q <= '0;
    end else if (state_d == FETCH_REQ) begin
      addr_q <= k_d;
    end
  end

  // Datapath registers: run parameters, weights, the current sample and the
  // registered scaled error. Row field j sits DATA_W*j bits below the MSBs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int j = 0; j <= NUM_FEATURES; j++) begin
        w_q[j] <= '0;
      end
      for (int i = 1; i <= NUM_FEATURES; i++) begin
        x_q[i] <= '0;
      end
      y_q  <= '0;
      c_q  <= '0;
      nd_q <= '0;
      te_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            nd_q <= num_dps;
            te_q <= total_epochs;
          end
        end
        LOAD_CAP: begin
          for (int j = 0; j <= NUM_FEATURES; j++) begin
            w_q[j] <= mem.mem_rdata[ROW_W-1-DATA_W*j -: DATA_W];
          end
        end
        FETCH_CAP: begin
          y_q <= mem.mem_rdata[ROW_W-1 -: DATA_W];
          for (int i = 1; i <= NUM_FEATURES; i++) begin
            x_q[i] <= mem.mem_rdata[ROW_W-1-DATA_W*i -: DATA_W];
          end
        end
        PREDICT: c_q <= c_d;
        UPDATE: begin
          w_q[0] <= sat_acc(ACC_W'(w_q[0]) + ACC_W'(c_q));
          for (int i = 1; i <= NUM_FEATURES; i++) begin
            w_q[i] <= sat_acc(ACC_W'(w_q[i]) + ACC_W'(prod[i]));
          end
        end
        default: ;
      endcase
    end
  end

  // Weight row packing for the write-back, w0 in the MSBs.
  always_comb begin
    mem.mem_wdata = '0;
    for (int j = 0; j <= NUM_FEATURES; j++) begin
      mem.mem_wdata[ROW_W-1-DATA_W*j -: DATA_W] = w_q[j];
    end
  end

  assign mem.mem_addr = addr_q;
  assign epoch        = epoch_q;

endmodule

// File: tb/tb_lr_sgd_engine.sv
// Self-checking bench for lr_sgd_engine at NUM_FEATURES=2, Q8.8.
//
// Purpose: a table of directed training runs with hand-computed final
// weights, run lengths and epoch counts, plus hand-written reset sequences.
// Ports: none (top-level bench).
module tb_lr_sgd_engine;

  localparam int NF = 2;
  localparam int DW = 16;
  localparam int FW = 8;
  localparam int AW = 4;
  localparam int LS = 7;
  localparam int RW = DW * (NF + 1);

  typedef struct {
    logic [RW-1:0] row0;
    logic [RW-1:0] row1;
    logic [RW-1:0] row2;
    logic [RW-1:0] row3;
    logic [AW-1:0] nd;
    logic [7:0]    te;
    logic [RW-1:0] exp_w;
    logic [7:0]    exp_epoch;
    int            exp_cycles;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] num_dps = '0;
  logic [7:0]    total_epochs = '0;
  logic          busy;
  logic          done;
  logic [7:0]    epoch;

  logic [RW-1:0] mem_arr [0:15];
  int            wr_count = 0;
  logic [RW-1:0] last_wdata = '0;
  logic [AW-1:0] last_waddr = '0;

  int   checks = 0;
  int   failures = 0;
  vec_t vecs [6];

  lr_sgd_engine_if #(.ADDR_W(AW), .ROW_W(RW)) bus ();

  lr_sgd_engine #(
    .NUM_FEATURES (NF),
    .DATA_W       (DW),
    .FRAC_W       (FW),
    .ADDR_W       (AW),
    .LR_SHIFT     (LS)
  ) dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .start        (start),
    .num_dps      (num_dps),
    .total_epochs (total_epochs),
    .mem          (bus),
    .busy         (busy),
    .done         (done),
    .epoch        (epoch)
  );

  always #5 clk = ~clk;

  // Row memory with one-cycle read latency; writes are recorded, not stored.
  always @(posedge clk) begin
    if (bus.mem_rd) begin
      bus.mem_rdata <= mem_arr[bus.mem_addr];
    end
    if (bus.mem_wr) begin
      wr_count   <= wr_count + 1;
      last_wdata <= bus.mem_wdata;
      last_waddr <= bus.mem_addr;
    end
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic [RW-1:0] r0, input logic [RW-1:0] r1,
                              input logic [RW-1:0] r2, input logic [RW-1:0] r3,
                              input logic [AW-1:0] nd, input logic [7:0] te,
                              input logic [RW-1:0] ew, input logic [7:0] ee,
                              input int ec);
    vec_t v;
    v.row0 = r0; v.row1 = r1; v.row2 = r2; v.row3 = r3;
    v.nd = nd; v.te = te; v.exp_w = ew; v.exp_epoch = ee; v.exp_cycles = ec;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic loadRows(input vec_t v);
    for (int r = 0; r < 16; r++) begin
      mem_arr[r] = '0;
    end
    mem_arr[0] = v.row0;
    mem_arr[1] = v.row1;
    mem_arr[2] = v.row2;
    mem_arr[3] = v.row3;
  endtask

  // Starts a run and lets n negedges pass after the start-sampling edge;
  // the run parameters are scrambled right after they have been latched.
  task automatic runUntil(input vec_t v, input int n);
    loadRows(v);
    @(negedge clk);
    start        = 1'b1;
    num_dps      = v.nd;
    total_epochs = v.te;
    @(posedge clk);
    #1;
    start        = 1'b0;
    num_dps      = '1;
    total_epochs = 8'hFF;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int cycles;
    int busy_low;
    int both;
    int wr_before;
    bit seen;
    cycles = 0; busy_low = 0; both = 0; seen = 1'b0;
    wr_before = wr_count;
    runUntil(v, 0);
    while (!seen && cycles < 1000) begin
      @(negedge clk);
      cycles++;
      if (!busy) busy_low++;
      if (bus.mem_rd && bus.mem_wr) both++;
      if (done) seen = 1'b1;
      start = (cycles == 2);
    end
    start = 1'b0;
    checkOutput($sformatf("v%0d_cycles", idx), 64'(cycles), 64'(v.exp_cycles));
    checkOutput($sformatf("v%0d_busy_low", idx), 64'(busy_low), 64'(0));
    checkOutput($sformatf("v%0d_rd_wr_both", idx), 64'(both), 64'(0));
    @(negedge clk);
    checkOutput($sformatf("v%0d_done_after", idx), 64'(done), 64'(0));
    checkOutput($sformatf("v%0d_busy_after", idx), 64'(busy), 64'(0));
    @(negedge clk);
    checkOutput($sformatf("v%0d_writes", idx), 64'(wr_count - wr_before), 64'(1));
    checkOutput($sformatf("v%0d_wdata", idx), 64'(last_wdata), 64'(v.exp_w));
    checkOutput($sformatf("v%0d_waddr", idx), 64'(last_waddr), 64'(0));
    checkOutput($sformatf("v%0d_epoch", idx), 64'(epoch), 64'(v.exp_epoch));
  endtask

  task automatic releaseReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int wr_before;

    // single step, zero error, saturation, zero epochs, zero points,
    // 3x2 timing, two-feature two-step update with negative error
    vecs[0] = mk({16'h0000, 16'h0000, 16'h0000}, {16'h4000, 16'h0100, 16'h0000}, '0, '0,
                 4'd1, 8'd1, {16'h0080, 16'h0080, 16'h0000}, 8'd1, 8);
    vecs[1] = mk({16'h0000, 16'h0100, 16'h0000}, {16'h0200, 16'h0200, 16'h0000},
                 {16'h0300, 16'h0300, 16'h0000}, '0,
                 4'd2, 8'd3, {16'h0000, 16'h0100, 16'h0000}, 8'd3, 28);
    vecs[2] = mk({16'h7FFF, 16'h7FFF, 16'h0000}, {16'h7F00, 16'h0100, 16'h0000}, '0, '0,
                 4'd1, 8'd1, {16'h7FFD, 16'h7FFD, 16'h0000}, 8'd1, 8);
    vecs[3] = mk({16'h1234, 16'h0F00, 16'hFF80}, {16'h4000, 16'h0100, 16'h0100}, '0, '0,
                 4'd2, 8'd0, {16'h1234, 16'h0F00, 16'hFF80}, 8'd0, 4);
    vecs[4] = mk({16'hABCD, 16'h0001, 16'h8000}, {16'h4000, 16'h0100, 16'h0100}, '0, '0,
                 4'd0, 8'd5, {16'hABCD, 16'h0001, 16'h8000}, 8'd0, 4);
    vecs[5] = mk({16'h0000, 16'h0100, 16'h0000}, {16'h0200, 16'h0200, 16'h1234},
                 {16'h0100, 16'h0100, 16'hF000}, {16'hFC00, 16'hFC00, 16'h0000},
                 4'd3, 8'd2, {16'h0000, 16'h0100, 16'h0000}, 8'd2, 28);

    // Reset state before any run.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_done", 64'(done), 64'(0));
    checkOutput("rst_mem_rd", 64'(bus.mem_rd), 64'(0));
    checkOutput("rst_mem_wr", 64'(bus.mem_wr), 64'(0));
    checkOutput("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
    checkOutput("rst_epoch", 64'(epoch), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], i);
    end
    applyStimulus(mk({16'h0000, 16'h0100, 16'h0080}, {16'h0300, 16'h0100, 16'h0200},
                     {16'hFE00, 16'hFF00, 16'h0000}, '0,
                     4'd2, 8'd1, {16'h0000, 16'h0104, 16'h0084}, 8'd1, 12), 6);

    // Reset while in UPDATE: outputs drop with no clock edge.
    runUntil(vecs[0], 6);
    checkOutput("upd_busy_pre", 64'(busy), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    checkOutput("upd_rst_busy", 64'(busy), 64'(0));
    checkOutput("upd_rst_mem_rd", 64'(bus.mem_rd), 64'(0));
    checkOutput("upd_rst_mem_wr", 64'(bus.mem_wr), 64'(0));
    checkOutput("upd_rst_epoch", 64'(epoch), 64'(0));
    releaseReset();

    // Reset while a data row is being requested.
    runUntil(vecs[0], 3);
    checkOutput("fetch_mem_rd_pre", 64'(bus.mem_rd), 64'(1));
    checkOutput("fetch_addr_pre", 64'(bus.mem_addr), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    checkOutput("fetch_rst_mem_rd", 64'(bus.mem_rd), 64'(0));
    checkOutput("fetch_rst_addr", 64'(bus.mem_addr), 64'(0));
    releaseReset();

    // Reset during WRITEBACK must suppress the memory write.
    wr_before = wr_count;
    runUntil(vecs[0], 7);
    checkOutput("wb_mem_wr_pre", 64'(bus.mem_wr), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    checkOutput("wb_rst_mem_wr", 64'(bus.mem_wr), 64'(0));
    releaseReset();
    checkOutput("wb_rst_no_write", 64'(wr_count - wr_before), 64'(0));

    // A fresh run after the aborted ones reproduces the single-step result.
    applyStimulus(vecs[0], 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lr_sgd_engine.md
LR_SGD_ENGINE -- requirements
Module: lr_sgd_engine

Interface
REQ-001 SHALL have parameter NUM_FEATURES, default 6, giving features per data point (1..15).
REQ-002 SHALL have parameter DATA_W, default 16, giving the signed fixed-point word width.
REQ-003 SHALL have parameter FRAC_W, default 8, giving the fraction bits (Q8.8 at defaults).
REQ-004 SHALL have parameter ADDR_W, default 4, giving the row-address width.
REQ-005 SHALL have parameter LR_SHIFT, default 7, giving the learning rate as 2^-LR_SHIFT.
REQ-006 SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port RST_N, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1 bit: begin a training run; sampled only in IDLE.
REQ-009 SHALL have port num_dps, input, ADDR_W bits: data points per epoch; latched at start.
REQ-010 SHALL have port total_epochs, input, 8 bits: epoch count; latched at start.
REQ-011 SHALL have port mem_addr, output, ADDR_W bits: row address.
REQ-012 SHALL have port mem_rd, output, 1 bit: read strobe; data is valid exactly one cycle later.
REQ-013 SHALL have port mem_rdata, input, DATA_W*(NUM_FEATURES+1) bits: row read data.
REQ-014 SHALL have port mem_wr, output, 1 bit: write strobe.
REQ-015 SHALL have port mem_wdata, output, DATA_W*(NUM_FEATURES+1) bits: packed weights.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-017 SHALL have port done, output, 1 bit: one-cycle pulse at run end.
REQ-018 SHALL have port epoch, output, 8 bits: number of completed epochs.

Function
REQ-019 SHALL use this row layout: field 0 occupies the MSBs and field j sits DATA_W*j bits below it; row 0 = {w0..wN}; row k (1..num_dps) = {y, x1..xN}.
REQ-020 SHALL implement these states: IDLE, LOAD_REQ, LOAD_CAP, FETCH_REQ, FETCH_CAP, PREDICT, UPDATE, WRITEBACK, DONE; all transitions are registered on CLK.
REQ-021 SHALL run IDLE -> LOAD_REQ on start; LOAD_REQ drives mem_rd=1 with address 0; LOAD_CAP latches all weights.
REQ-022 SHALL go LOAD_CAP -> WRITEBACK when num_dps==0 or total_epochs==0; otherwise LOAD_CAP -> FETCH_REQ with k=1.
REQ-023 SHALL spend four cycles per data point:
- FETCH_REQ: mem_rd=1, address k.
- FETCH_CAP: latch y and x.
- PREDICT: y_cap=sat(w0+sum(xi*wi)); c=(y-y_cap)>>>LR_SHIFT, registered.
- UPDATE: w0=sat(w0+c); wi=sat(wi+xi*c).
REQ-024 SHALL leave UPDATE as follows:
- k<num_dps: k++, go to FETCH_REQ.
- k==num_dps: epoch++, k=1; go to WRITEBACK if the epoch equals total_epochs, else FETCH_REQ.
REQ-025 SHALL in WRITEBACK drive mem_wr=1 for one cycle with address 0 and mem_wdata = packed weights; then DONE, where done=1 for one cycle, then IDLE.
REQ-026 SHALL take a multiply as the full product, arithmetic-shifted right by FRAC_W and saturated to DATA_W; all adds SHALL saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-027 SHALL make the >>> operation an arithmetic shift (round toward minus infinity).
REQ-028 SHALL ignore start when not in IDLE; num_dps and total_epochs changes mid-run SHALL have no effect.
REQ-029 SHALL keep mem_rd and mem_wr mutually exclusive and low outside the states listed above; mem_addr holds its last value elsewhere.
REQ-030 SHALL take exactly 4 + 4*num_dps*total_epochs cycles from the start-sampling edge to the done pulse when both are nonzero, and 4 cycles otherwise.

Reset
REQ-031 SHALL on RST_N low immediately force state to IDLE and clear weights, k, epoch, mem_addr, mem_rd, mem_wr, busy and done to 0; mid-run reset SHALL abort with no memory write.
REQ-032 SHALL accept the first start only after RST_N has been high for one rising edge.

Structure
REQ-033 SHALL place the state encodings, the default DATA_W/FRAC_W and the saturation limits in the shared package lr_pkg.
REQ-034 SHALL implement the multiply in sub-module fx_mul (signed saturating fixed-point multiply), instantiated NUM_FEATURES times; its B operand is muxed between wi (PREDICT) and c (UPDATE).

Verification (NUM_FEATURES=2, Q8.8)
REQ-035 SHALL cover single step: row0={0,0,0}, row1={0x4000,0x0100,0x0000}, num_dps=1, total_epochs=1 -> written row0={0x0080,0x0080,0x0000}.
REQ-036 SHALL cover zero error: row0={0,0x0100,0}, rows {y=x1} with x1=0x0200,0x0300, 3 epochs -> weights unchanged; write occurs once.
REQ-037 SHALL cover saturation: row0={0x7FFF,0x7FFF,0}, x1=0x0100 -> y_cap=0x7FFF, no wrap.
REQ-038 SHALL cover timing: num_dps=3, total_epochs=2 -> done 28 cycles after start; epoch=2; busy was high throughout.
REQ-039 SHALL cover zero epochs: total_epochs=0 -> row0 written back unchanged; done 4 cycles after start.
REQ-040 SHALL cover reset mid-run: RST_N low during UPDATE -> busy, mem_rd, mem_wr low without a clock edge; a fresh start then reproduces REQ-035.
